branch_resolve: RTL and testbench

- Branch resolution stage directly downstream of the register comparator in the EX stage.
- Consumes the 5-bit compare vector {equal, not-equal, less-than, greater-than, in1-zero}, the decoded branch type, the PC and the offset.
- Decides taken/not-taken and computes the target. Detects mispredictions against the IF-stage prediction and issues a one-cycle redirect/flush.
- Maintains a small 2-bit-counter branch history table (BHT) that IF queries combinationally.

---
 rtl/mips_pkg.sv | 37 +++
 rtl/branch_resolve_if.sv | 29 ++
 rtl/bht_2bit.sv | 35 +++
 rtl/branch_resolve.sv | 112 +++++++++++
 tb/tb_branch_resolve.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the comparator and the branch resolution stage.
//   br_type_e : decoded branch type encodings (BR_NONE..BR_JUMP, BR_RSVD)
//   CMP_*     : bit positions inside the 5-bit compare vector {eq, ne, lt, gt, zero}
//   BHT_RESET : reset value of every branch history counter (weakly not-taken)
//   bht_next  : saturating 2-bit counter update
package mips_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGT  = 3'd4,
    BR_BZ   = 3'd5,
    BR_JUMP = 3'd6,
    BR_RSVD = 3'd7
  } br_type_e;

  localparam int unsigned CMP_EQ   = 4;
  localparam int unsigned CMP_NE   = 3;
  localparam int unsigned CMP_LT   = 2;
  localparam int unsigned CMP_GT   = 1;
  localparam int unsigned CMP_ZERO = 0;

  localparam logic [1:0] BHT_RESET = 2'b01;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && cnt != 2'b11)
      nxt = cnt + 2'b01;
    else if (!taken && cnt != 2'b00)
      nxt = cnt - 2'b01;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// EX-stage branch bus between the pipeline and the branch resolution stage.
//   master : pipeline side, drives the EX instruction and observes the redirect
//   slave  : branch_resolve side
// Signals: valid_in, br_type, compare_in, pc_in, offset_in, pred_taken_in (to resolver);
//          redirect_valid, redirect_pc, flush, br_taken (from resolver).
interface branch_resolve_if #(
  parameter int unsigned PC_W = 32
);
  logic            valid_in;
  logic [2:0]      br_type;
  logic [4:0]      compare_in;
  logic [PC_W-1:0] pc_in;
  logic [15:0]     offset_in;
  logic            pred_taken_in;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            br_taken;

  modport master (
    output valid_in, br_type, compare_in, pc_in, offset_in, pred_taken_in,
    input  redirect_valid, redirect_pc, flush, br_taken
  );

  modport slave (
    input  valid_in, br_type, compare_in, pc_in, offset_in, pred_taken_in,
    output redirect_valid, redirect_pc, flush, br_taken
  );
endinterface

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters.
//   clk, rst     : clock, synchronous active-high reset (all entries -> weakly not-taken)
//   rd_idx_i     : combinational lookup index
//   rd_taken_o   : MSB of the addressed counter (pre-update value on same-cycle write)
//   upd_i        : update strobe (caller gates with stall)
//   upd_idx_i    : index to update
//   upd_taken_i  : resolved direction, counts up if taken, down otherwise
module bht_2bit
  import mips_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_taken_o,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [1:0] cnt_q [DEPTH];

  assign rd_taken_o = cnt_q[rd_idx_i][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        cnt_q[i] <= BHT_RESET;
    end else if (upd_i) begin
      cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
    end
  end
endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: decides direction, computes the target, detects
// mispredictions against the IF prediction, issues a one-cycle redirect/flush and
// trains the branch history table that IF queries combinationally.
//   clk, rst          : clock, synchronous active-high reset (overrides stall)
//   stall             : pipeline hold, freezes all state
//   ex                : EX branch bus (slave side)
//   lookup_pc         : IF-stage PC for the prediction query
//   pred_taken_out    : combinational prediction for lookup_pc
//   br_count          : resolved conditional branches, saturating
//   mispredict_count  : mispredictions, saturating
module branch_resolve
  import mips_pkg::*;
#(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BHT_IDX_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  branch_resolve_if.slave    ex,
  input  logic [PC_W-1:0]    lookup_pc,
  output logic               pred_taken_out,
  output logic [CNT_W-1:0]   br_count,
  output logic [CNT_W-1:0]   mispredict_count
);
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            redirect_q, redirect_d;
  logic [PC_W-1:0] rpc_q, rpc_d;
  logic            taken_q, taken_d;
  logic [CNT_W-1:0] brc_q, brc_d;
  logic [CNT_W-1:0] misc_q, misc_d;

  logic            taken, is_branch, is_cond;
  logic            resolve, mispredict;
  logic [PC_W-1:0] fall_pc, target_pc;

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b1;
    is_cond   = 1'b1;
    case (br_type_e'(ex.br_type))
      BR_BEQ:  taken = ex.compare_in[CMP_EQ];
      BR_BNE:  taken = ex.compare_in[CMP_NE];
      BR_BLT:  taken = ex.compare_in[CMP_LT];
      BR_BGT:  taken = ex.compare_in[CMP_GT];
      BR_BZ:   taken = ex.compare_in[CMP_ZERO];
      BR_JUMP: begin taken = 1'b1; is_cond = 1'b0; end
      default: begin is_branch = 1'b0; is_cond = 1'b0; end
    endcase
  end

  assign fall_pc   = ex.pc_in + PC_W'(4);
  assign target_pc = fall_pc + {{(PC_W-18){ex.offset_in[15]}}, ex.offset_in, 2'b00};

  // SQUASH discards the wrong-path EX instruction by masking resolution.
  assign resolve    = ex.valid_in && (state_q == ST_RUN) && !stall && is_branch;
  assign mispredict = resolve && (taken ^ ex.pred_taken_in);

  always_comb begin
    state_d    = (state_q == ST_SQUASH) ? ST_RUN : (mispredict ? ST_SQUASH : ST_RUN);
    redirect_d = mispredict;
    rpc_d      = rpc_q;
    taken_d    = taken_q;
    brc_d      = brc_q;
    misc_d     = misc_q;
    if (mispredict) begin
      rpc_d = taken ? target_pc : fall_pc;
      if (misc_q != '1) misc_d = misc_q + CNT_W'(1);
    end
    if (resolve) taken_d = taken;
    if (resolve && is_cond && brc_q != '1) brc_d = brc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      taken_q    <= 1'b0;
      brc_q      <= '0;
      misc_q     <= '0;
    end else if (!stall) begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      taken_q    <= taken_d;
      brc_q      <= brc_d;
      misc_q     <= misc_d;
    end
  end

  bht_2bit #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (lookup_pc[BHT_IDX_W+1:2]),
    .rd_taken_o  (pred_taken_out),
    .upd_i       (resolve && is_cond),
    .upd_idx_i   (ex.pc_in[BHT_IDX_W+1:2]),
    .upd_taken_i (taken)
  );

  assign ex.redirect_valid = redirect_q;
  assign ex.flush          = redirect_q;
  assign ex.redirect_pc    = rpc_q;
  assign ex.br_taken       = taken_q;
  assign br_count          = brc_q;
  assign mispredict_count  = misc_q;
endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] lookup_pc;
  logic        pred_taken_out;
  logic [15:0] br_count, mispredict_count;

  branch_resolve_if #(.PC_W(32)) bus ();

  branch_resolve #(.PC_W(32), .BHT_IDX_W(4), .CNT_W(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex               (bus),
    .lookup_pc        (lookup_pc),
    .pred_taken_out   (pred_taken_out),
    .br_count         (br_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integers and arrays.
  int          m_bht [16];
  bit          m_squash;
  bit          m_redir;
  logic [31:0] m_rpc;
  bit          m_taken;
  int          m_brc, m_misc;
  bit          m_known = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic model_edge();
    int  t;
    bit  tk, res, mis;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
      m_squash = 0; m_redir = 0; m_rpc = 0; m_taken = 0; m_brc = 0; m_misc = 0;
      m_known = 1;
      return;
    end
    if (stall) return;
    t   = int'(bus.br_type);
    res = bus.valid_in && !m_squash && t >= 1 && t <= 6;
    case (t)
      1: tk = bus.compare_in[4];
      2: tk = bus.compare_in[3];
      3: tk = bus.compare_in[2];
      4: tk = bus.compare_in[1];
      5: tk = bus.compare_in[0];
      6: tk = 1;
      default: tk = 0;
    endcase
    mis = res && (tk != bus.pred_taken_in);
    m_redir = mis;
    if (mis) begin
      if (tk) m_rpc = bus.pc_in + 32'd4 + 32'(int'($signed(bus.offset_in)) * 4);
      else    m_rpc = bus.pc_in + 32'd4;
      if (m_misc < 65535) m_misc++;
    end
    if (res) m_taken = tk;
    if (res && t <= 5) begin
      if (m_brc < 65535) m_brc++;
      if (tk && m_bht[idx(bus.pc_in)] < 3) m_bht[idx(bus.pc_in)]++;
      if (!tk && m_bht[idx(bus.pc_in)] > 0) m_bht[idx(bus.pc_in)]--;
    end
    m_squash = m_squash ? 0 : mis;
  endtask

  // One clock: check the combinational prediction, advance the model, check registered outputs.
  task automatic step();
    #1;
    if (m_known) chk("pred_taken_out", pred_taken_out, m_bht[idx(lookup_pc)] >= 2);
    model_edge();
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("redirect_valid", bus.redirect_valid, m_redir);
      chk("flush", bus.flush, m_redir);
      chk("redirect_pc", bus.redirect_pc, m_rpc);
      chk("br_taken", bus.br_taken, m_taken);
      chk("br_count", br_count, m_brc);
      chk("mispredict_count", mispredict_count, m_misc);
    end
  endtask

  task automatic drive(input bit v, input int t, input logic [4:0] c, input logic [31:0] pc,
                       input logic [15:0] off, input bit pred);
    bus.valid_in = v; bus.br_type = 3'(t); bus.compare_in = c;
    bus.pc_in = pc; bus.offset_in = off; bus.pred_taken_in = pred;
  endtask

  initial begin
    rst = 1; stall = 0; lookup_pc = 32'h40;
    drive(0, 0, 5'b0, 32'h0, 16'h0, 0);
    @(negedge clk);
    step(); step();
    rst = 0;
    step();
    chk("reset_pred_lit", pred_taken_out, 1'b0);
    chk("reset_brc_lit", br_count, 16'd0);
    chk("reset_flush_lit", bus.flush, 1'b0);

    // beq taken, predicted not-taken
    drive(1, 1, 5'b10001, 32'h100, 16'd3, 0);
    step();
    chk("beq_redir_lit", bus.redirect_valid, 1'b1);
    chk("beq_flush_lit", bus.flush, 1'b1);
    chk("beq_rpc_lit", bus.redirect_pc, 32'h110);
    chk("beq_misc_lit", mispredict_count, 16'd1);
    step(); // SQUASH cycle, same wrong-path beq
    chk("squash_redir_lit", bus.redirect_valid, 1'b0);
    chk("squash_misc_lit", mispredict_count, 16'd1);
    chk("squash_brc_lit", br_count, 16'd1);

    // bne not taken, predicted taken
    drive(1, 2, 5'b10000, 32'h200, 16'd5, 1);
    step();
    chk("bne_rpc_lit", bus.redirect_pc, 32'h204);
    chk("bne_taken_lit", bus.br_taken, 1'b0);
    drive(0, 0, 5'b0, 32'h0, 16'h0, 0);
    step();

    // five taken blt at 0x300, correctly predicted taken
    lookup_pc = 32'h300;
    for (int i = 0; i < 5; i++) begin
      drive(1, 3, 5'b00100, 32'h300, 16'h10, 1);
      step();
    end
    drive(0, 0, 5'b0, 32'h0, 16'h0, 0);
    step();
    chk("blt_sat_pred_lit", pred_taken_out, 1'b1);

    // stalled mispredict with wrapping target
    drive(1, 1, 5'b10000, 32'h10, 16'h8000, 0);
    stall = 1; step(); step();
    chk("stall_redir_lit", bus.redirect_valid, 1'b0);
    stall = 0; step();
    chk("wrap_redir_lit", bus.redirect_valid, 1'b1);
    chk("wrap_rpc_lit", bus.redirect_pc, 32'hFFFE0014);
    stall = 1; step();
    chk("stall_hold_redir_lit", bus.redirect_valid, 1'b1);
    stall = 0; step();
    chk("pulse_end_lit", bus.flush, 1'b0);

    // reset during SQUASH with stall high
    drive(1, 6, 5'b0, 32'h300, 16'h4, 0);
    step();
    stall = 1; rst = 1; step();
    chk("rst_sq_redir_lit", bus.redirect_valid, 1'b0);
    chk("rst_sq_misc_lit", mispredict_count, 16'd0);
    chk("rst_sq_pred_lit", pred_taken_out, 1'b0);
    rst = 0; stall = 0;
    drive(1, 1, 5'b10000, 32'h300, 16'h4, 0);
    step(); // FSM back in RUN: resolves and redirects
    chk("rst_run_lit", bus.redirect_valid, 1'b1);

    // randomized stimulus
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc;
      pc = ($urandom & 32'hFFFF0000) | ($urandom & 32'h0000_00FC);
      rst   = ($urandom_range(0, 99) == 0);
      stall = ($urandom_range(0, 3) == 0);
      lookup_pc = ($urandom_range(0, 1) == 0) ? pc : $urandom;
      drive($urandom_range(0, 4) != 0, int'($urandom_range(0, 7)), 5'($urandom), pc,
            16'($urandom),
            ($urandom_range(0, 1) == 0) ? (m_bht[idx(pc)] >= 2) : 1'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
